// File: rtl/reg_file_pkg.sv
// Shared constants, types and the index range helper for the 2-read/1-write register file.
package reg_file_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_DEPTH  = 16;
    localparam int REGFILE_ADDR_W = $clog2(REGFILE_DEPTH);

    typedef logic [REGFILE_ADDR_W-1:0] regfile_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] regfile_data_t;

    function automatic logic regfile_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/reg_file_wr_decoder.sv
// One-hot strobe decoder with range check; ZERO_REG_EN masks entry 0 (hardwired zero register).
module reg_file_wr_decoder
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DEPTH-1:0]  onehot_o
);

`ifdef ZERO_REG_EN
    localparam logic ZERO_MASK = 1'b1;
`else
    localparam logic ZERO_MASK = 1'b0;
`endif

    logic in_range_s;

    // Decode the strobe into one enable per register, dropping out-of-range and masked entries
    always_comb begin
        onehot_o   = {DEPTH{1'b0}};
        in_range_s = regfile_in_range(32'(addr_i), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            onehot_o[i] = en_i && in_range_s && (addr_i == ADDR_W'(i))
                          && !(ZERO_MASK && (i == 0));
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one write port, two registered write-first read ports, busy bits.
// Build option ZERO_REG_EN makes register 0 a hardwired zero.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd0_busy,
    output logic              rd1_busy
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  wr_hit_s;
    logic [DEPTH-1:0]  bs_hit_s;
    logic              rd0_ok_s;
    logic              rd1_ok_s;
    logic [DATA_W-1:0] rd0_data_q;
    logic [DATA_W-1:0] rd1_data_q;
    logic              rd0_busy_q;
    logic              rd1_busy_q;

    reg_file_wr_decoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_dec (
        .en_i     (wr_en),
        .addr_i   (wr_addr),
        .onehot_o (wr_hit_s)
    );

    reg_file_wr_decoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_busy_dec (
        .en_i     (busy_set),
        .addr_i   (busy_addr),
        .onehot_o (bs_hit_s)
    );

    // Next-state array: clear dominates, a new busy_set beats the completing write
    always_comb begin
        rd0_ok_s = regfile_in_range(32'(rd0_addr), DEPTH);
        rd1_ok_s = regfile_in_range(32'(rd1_addr), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = clr ? {DATA_W{1'b0}} : (wr_hit_s[i] ? wr_data : regs_q[i]);
            busy_d[i] = clr ? 1'b0 : (bs_hit_s[i] | (busy_q[i] & ~wr_hit_s[i]));
        end
    end

    // Register array and busy bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            busy_q <= {DEPTH{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read port 0 with write-first bypass
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd0_data_q <= {DATA_W{1'b0}};
            rd0_busy_q <= 1'b0;
        end else if (clr || !rd0_ok_s) begin
            rd0_data_q <= {DATA_W{1'b0}};
            rd0_busy_q <= 1'b0;
        end else if (wr_hit_s[rd0_addr]) begin
            rd0_data_q <= wr_data;
            rd0_busy_q <= busy_d[rd0_addr];
        end else begin
            rd0_data_q <= regs_q[rd0_addr];
            rd0_busy_q <= busy_d[rd0_addr];
        end
    end

    // Read port 1 with write-first bypass
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_data_q <= {DATA_W{1'b0}};
            rd1_busy_q <= 1'b0;
        end else if (clr || !rd1_ok_s) begin
            rd1_data_q <= {DATA_W{1'b0}};
            rd1_busy_q <= 1'b0;
        end else if (wr_hit_s[rd1_addr]) begin
            rd1_data_q <= wr_data;
            rd1_busy_q <= busy_d[rd1_addr];
        end else begin
            rd1_data_q <= regs_q[rd1_addr];
            rd1_busy_q <= busy_d[rd1_addr];
        end
    end

    assign rd0_data = rd0_data_q;
    assign rd1_data = rd1_data_q;
    assign rd0_busy = rd0_busy_q;
    assign rd1_busy = rd1_busy_q;

endmodule
